mux_pipe: RTL and testbench
===========================

// Module: mux_pipe
//
// PURPOSE
//   Parametrised N:1 multiplexer, W bits wide, with a registered output
//   stage and valid/ready flow control on every channel.
//   It succeeds the fixed 8:1 combinational muxes and adds two select modes:
//   explicit select, or round-robin arbitration among requesting inputs.
//   It sits between producers, such as register-file or bus read ports, and
//   one consumer that may stall.
//
// PARAMETERS
//   W     16  data width per channel, >= 1
//   N     8   number of input channels, >= 2
//   MODE  0   0 = explicit select via sel; 1 = round-robin over in_valid
//   SELW  localparam = $clog2(N), width of the channel index
//
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_data    in   N*W    packed channels; channel i is bits [i*W +: W]
//   in_valid   in   N      channel i has data
//   in_ready   out  N      channel i is accepted this cycle (combinational)
//   sel        in   SELW   channel select, used only in MODE 0
//   out_data   out  W      registered selected data
//   out_chan   out  SELW   index of the channel held in out_data
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer accepts out_data
//   out_par    out  1      even parity of out_data; only with MUX_PIPE_PARITY_EN
//
// BEHAVIOUR
//   - Reset (async assert, sync release): out_valid=0, out_data=0,
//     out_chan=0, out_par=0, rr_ptr=0. Reset mid-transfer discards held data.
//   - load = !out_valid || out_ready. This is one pipeline register, with no
//     skid buffer.
//   - The grant vector g is one-hot or zero:
//       MODE 0: g[sel] = in_valid[sel]; sel >= N gives g = 0.
//       MODE 1: g = first set bit of in_valid, searching upward from rr_ptr
//               with wrap-around (rr_ptr, rr_ptr+1, ..., N-1, 0, ...).
//   - in_ready[i] = load && g[i].
//   - Transfer in: occurs when load && |g.
//     - At the next edge: out_data <= channel data, out_chan <= index,
//       out_valid <= 1.
//     - Latency is one clock from input accept to out_valid.
//   - load && !|g: out_valid <= 0 at the next edge; out_data and out_chan
//     keep their old values.
//   - Output hold: while out_valid && !out_ready, out_data, out_chan and
//     out_par are stable, and in_ready = 0.
//     - Changes on sel or in_valid have no effect until the consumer accepts.
//   - Simultaneous accept and load: a new word is accepted in the same cycle
//     the held word leaves, giving full throughput of 1 word/clk.
//   - rr_ptr (MODE 1 only) changes only on a transfer in:
//     - rr_ptr <= granted index + 1, wrapping N-1 -> 0.
//     - rr_ptr is unchanged when there is no grant or the output is stalled.
//   - A single requester is granted every cycle regardless of rr_ptr.
//   - Starvation bound (MODE 1): a channel held valid is granted within N
//     transfers.
//   - Producers may drop in_valid before they are accepted. The block keeps
//     no state about requests that were not granted.
//
// CONFIGURATION
//   MUX_PIPE_PARITY_EN
//     defined:   out_par port exists. It is registered with out_data as
//                ^in_data of the granted channel, so out_par == ^out_data
//                whenever out_valid == 1.
//     undefined: out_par port and logic are absent. All other behaviour is
//                identical.
//
// TESTING  (W=16, N=8 unless stated)
//   1. Reset with all in_valid=1 and out_ready=1 -> out_valid=0 and
//      in_ready=0 while rst=1. The first out_valid rises one clock after
//      release.
//   2. MODE0, sel=3, in3=16'hA5C3 valid, out_ready=1 -> in_ready=8'h08.
//      Next clk: out_data=16'hA5C3, out_chan=3, out_valid=1.
//   3. MODE0 stall: out_ready=0 with a word held, then sel changes 3->5
//      -> out_data stays 16'hA5C3 and in_ready=0.
//      After out_ready=1, channel 5 data appears one clk later.
//   4. MODE1, in_valid=8'b1000_0101 held, out_ready=1 -> out_chan sequence
//      0,2,7,0,2,7. With out_ready toggling 1,0,1 the sequence is unchanged
//      and nothing is skipped.
//   5. MODE1, N=3, rr_ptr=2, only in_valid[0] set -> channel 0 is granted.
//      rr_ptr wraps to 1.
//   6. With MUX_PIPE_PARITY_EN and data 16'h0007 -> out_par=1.
//      With data 16'h0003 -> out_par=0.
//      Rebuild without the macro: tests 2-5 pass unchanged.

Source files
------------

// File: rtl/mux_pipe.sv
// N:1 valid/ready multiplexer into one output register; explicit select (MODE 0) or round-robin (MODE 1).
// Latency: one clock from input accept to out_valid.
// Backpressure: a held word blocks all inputs (in_ready = 0) until out_ready; no skid buffer.
// Optional: define MUX_PIPE_PARITY_EN to add the registered even-parity output out_par.
module mux_pipe #(
   parameter  int W    = 16,
   parameter  int N    = 8,
   parameter  int MODE = 0,
   localparam int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_chan,
   output logic            out_valid,
   input  logic            out_ready
`ifdef MUX_PIPE_PARITY_EN
   ,
   output logic            out_par
`endif
);

   logic [W-1:0]    out_data_q, out_data_d;
   logic [SELW-1:0] out_chan_q, out_chan_d;
   logic            out_valid_q, out_valid_d;
   logic [SELW-1:0] rr_q, rr_d;
`ifdef MUX_PIPE_PARITY_EN
   logic            out_par_q, out_par_d;
`endif

   logic            load;
   logic [N-1:0]    gnt;
   logic [SELW-1:0] gnt_idx;
   logic            gnt_any;
   logic [W-1:0]    gnt_dat;

   // The output register can take a new word when empty or when its word leaves this cycle
   assign load = !out_valid_q || out_ready;

   // Grant selection: one-hot or zero; a select value of N or more matches no channel
   always_comb begin : grant_sel
      int idx;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      gnt_dat = '0;
      if (MODE == 0) begin
         for (int i = 0; i < N; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
               gnt[i]  = 1'b1;
               gnt_idx = SELW'(i);
               gnt_any = 1'b1;
               gnt_dat = in_data[i*W +: W];
            end
         end
      end else begin
         // Search upward from rr_q with wrap-around; first requester wins
         for (int k = 0; k < N; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!gnt_any && in_valid[idx]) begin
               gnt[idx] = 1'b1;
               gnt_idx  = SELW'(idx);
               gnt_any  = 1'b1;
               gnt_dat  = in_data[idx*W +: W];
            end
         end
      end
   end

   // Accept only while the output register can load; nothing is accepted during reset
   assign in_ready = (load && !rst) ? gnt : '0;

   // Next state: load a granted word, or drop valid when nothing is granted; data/chan hold otherwise
   always_comb begin
      out_data_d  = out_data_q;
      out_chan_d  = out_chan_q;
      out_valid_d = out_valid_q;
      rr_d        = rr_q;
`ifdef MUX_PIPE_PARITY_EN
      out_par_d   = out_par_q;
`endif
      if (load) begin
         out_valid_d = gnt_any;
         if (gnt_any) begin
            out_data_d = gnt_dat;
            out_chan_d = gnt_idx;
`ifdef MUX_PIPE_PARITY_EN
            out_par_d  = ^gnt_dat;
`endif
            // Pointer moves past the winner only on a real transfer
            if (MODE != 0) begin
               rr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
            end
         end
      end
   end

   // Output pipeline register and round-robin pointer; reset discards any held word
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_data_q  <= '0;
         out_chan_q  <= '0;
         out_valid_q <= 1'b0;
         rr_q        <= '0;
`ifdef MUX_PIPE_PARITY_EN
         out_par_q   <= 1'b0;
`endif
      end else begin
         out_data_q  <= out_data_d;
         out_chan_q  <= out_chan_d;
         out_valid_q <= out_valid_d;
         rr_q        <= rr_d;
`ifdef MUX_PIPE_PARITY_EN
         out_par_q   <= out_par_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;
   assign out_valid = out_valid_q;
`ifdef MUX_PIPE_PARITY_EN
   assign out_par   = out_par_q;
`endif

endmodule

// File: tb/tb_mux_pipe.sv
// Directed bench for mux_pipe: explicit-select, round-robin (N=8) and round-robin (N=3) instances.
// Inputs are driven and outputs sampled on the falling edge; combinational in_ready is read #1 later.
// With MUX_PIPE_PARITY_EN defined, out_par is also checked.
module tb_mux_pipe;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // explicit select, N=8
   logic [127:0] in_data0;
   logic [7:0]   in_valid0, in_ready0;
   logic [2:0]   sel0, out_chan0;
   logic [15:0]  out_data0;
   logic         out_valid0, out_ready0;
   // round-robin, N=8
   logic [127:0] in_data1;
   logic [7:0]   in_valid1, in_ready1;
   logic [2:0]   sel1, out_chan1;
   logic [15:0]  out_data1;
   logic         out_valid1, out_ready1;
   // round-robin, N=3
   logic [47:0]  in_data2;
   logic [2:0]   in_valid2, in_ready2;
   logic [1:0]   sel2, out_chan2;
   logic [15:0]  out_data2;
   logic         out_valid2, out_ready2;
`ifdef MUX_PIPE_PARITY_EN
   logic         out_par0, out_par1, out_par2;
`endif

   mux_pipe #(.W(16), .N(8), .MODE(0)) u_sel (
      .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
      .sel(sel0), .out_data(out_data0), .out_chan(out_chan0), .out_valid(out_valid0),
      .out_ready(out_ready0)
`ifdef MUX_PIPE_PARITY_EN
      , .out_par(out_par0)
`endif
   );

   mux_pipe #(.W(16), .N(8), .MODE(1)) u_rr8 (
      .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
      .sel(sel1), .out_data(out_data1), .out_chan(out_chan1), .out_valid(out_valid1),
      .out_ready(out_ready1)
`ifdef MUX_PIPE_PARITY_EN
      , .out_par(out_par1)
`endif
   );

   mux_pipe #(.W(16), .N(3), .MODE(1)) u_rr3 (
      .clk(clk), .rst(rst), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
      .sel(sel2), .out_data(out_data2), .out_chan(out_chan2), .out_valid(out_valid2),
      .out_ready(out_ready2)
`ifdef MUX_PIPE_PARITY_EN
      , .out_par(out_par2)
`endif
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   int rr_seq[6]  = '{0, 2, 7, 0, 2, 7};
   int tgl_rdy[6] = '{1, 0, 1, 0, 1, 0};
   int tgl_chn[6] = '{0, 0, 2, 2, 7, 7};

   initial begin
      rst = 1'b1;
      in_data0 = '0; in_data1 = '0; in_data2 = '0;
      in_data0[0*16 +: 16] = 16'h0007;
      in_data0[1*16 +: 16] = 16'h0003;
      in_data0[3*16 +: 16] = 16'hA5C3;
      in_data0[5*16 +: 16] = 16'h5A5A;
      for (int i = 0; i < 8; i++) in_data1[i*16 +: 16] = 16'(16'hC000 + i);
      for (int i = 0; i < 3; i++) in_data2[i*16 +: 16] = 16'(16'h00B0 + i);
      in_valid0 = 8'hFF; sel0 = 3'd0; out_ready0 = 1'b1;
      in_valid1 = 8'hFF; sel1 = 3'd0; out_ready1 = 1'b1;
      in_valid2 = 3'b000; sel2 = 2'd0; out_ready2 = 1'b1;

      // reset with every input requesting and the consumer ready
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid0", out_valid0, 0);
      check("rst_ready0", in_ready0, 8'h00);
      check("rst_valid1", out_valid1, 0);
      check("rst_ready1", in_ready1, 8'h00);
      check("rst_data0", out_data0, 16'h0000);
      check("rst_chan0", out_chan0, 0);
      rst = 1'b0;
      @(negedge clk);
      check("first_valid0", out_valid0, 1);
      check("first_data0", out_data0, 16'h0007);
      check("first_chan1", out_chan1, 0);

      // explicit select of channel 3
      sel0 = 3'd3; in_valid0 = 8'h08;
      #1 check("sel3_in_ready", in_ready0, 8'h08);
      @(negedge clk);
      check("sel3_data", out_data0, 16'hA5C3);
      check("sel3_chan", out_chan0, 3);
      check("sel3_valid", out_valid0, 1);

      // stall, then move select to channel 5 while held
      out_ready0 = 1'b0; sel0 = 3'd5; in_valid0 = 8'h20;
      #1 check("stall_in_ready", in_ready0, 8'h00);
      @(negedge clk);
      check("stall_data", out_data0, 16'hA5C3);
      check("stall_chan", out_chan0, 3);
      check("stall_valid", out_valid0, 1);
      check("stall_in_ready2", in_ready0, 8'h00);
      out_ready0 = 1'b1;
      #1 check("release_in_ready", in_ready0, 8'h20);
      @(negedge clk);
      check("sel5_data", out_data0, 16'h5A5A);
      check("sel5_chan", out_chan0, 5);

      // no request: valid drops, data and channel hold
      in_valid0 = 8'h00;
      @(negedge clk);
      check("idle_valid", out_valid0, 0);
      check("idle_data", out_data0, 16'h5A5A);
      check("idle_chan", out_chan0, 5);

`ifdef MUX_PIPE_PARITY_EN
      sel0 = 3'd0; in_valid0 = 8'h01;
      @(negedge clk);
      check("par_0007", out_par0, 1);
      sel0 = 3'd1; in_valid0 = 8'h02;
      @(negedge clk);
      check("par_0003", out_par0, 0);
      check("par_data", out_data0, 16'h0003);
`endif

      // reset mid-stream discards the held round-robin word
      out_ready1 = 1'b0; in_valid1 = 8'h00;
      rst = 1'b1;
      #1 check("midrst_valid1", out_valid1, 0);
      check("midrst_data1", out_data1, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // round-robin over channels 0, 2, 7
      in_valid1 = 8'b1000_0101; out_ready1 = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("rr_chan%0d", i), out_chan1, rr_seq[i]);
         check($sformatf("rr_valid%0d", i), out_valid1, 1);
      end
      check("rr_data7", out_data1, 16'hC007);

      // consumer toggling ready: no channel skipped
      for (int i = 0; i < 6; i++) begin
         out_ready1 = tgl_rdy[i][0];
         @(negedge clk);
         check($sformatf("tgl_chan%0d", i), out_chan1, tgl_chn[i]);
      end

      // single requester is granted every cycle
      in_valid1 = 8'h10; out_ready1 = 1'b1;
      #1 check("single_in_ready", in_ready1, 8'h10);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("single_chan%0d", i), out_chan1, 4);
      end

      // N=3: move pointer to 2, then only channel 0 requests
      in_valid2 = 3'b010;
      @(negedge clk);
      check("n3_chan1", out_chan2, 1);
      in_valid2 = 3'b001;
      #1 check("n3_in_ready", in_ready2, 3'b001);
      @(negedge clk);
      check("n3_chan0", out_chan2, 0);
      check("n3_data0", out_data2, 16'h00B0);
      // pointer wrapped to 1, so channel 1 wins among all three
      in_valid2 = 3'b111;
      #1 check("n3_wrap_ready", in_ready2, 3'b010);
      @(negedge clk);
      check("n3_wrap_chan", out_chan2, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
